dtb_daq_merge: RTL and testbench

Parametrised successor to the fixed two-source DAQ channel-0 merge. It collects NCH independent write-only 16-bit streams (ADC readout, deser160, deser400 lanes) in per-channel FIFOs, arbitrates them round-robin and issues one merged write stream to a DAQ output channel. Unlike the unbuffered OR merge, simultaneous source writes lose no data, and the block honours output backpressure. Overflows are flagged per channel and counted.

---
 rtl/dtb_daq_merge.sv | 181 ++++++++++++++++++
 tb/tb_dtb_daq_merge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtb_daq_merge.sv
// dtb_daq_merge: NCH per-channel FIFOs merged round-robin onto one registered DAQ write stream.
// Define DAQ_MERGE_TAG_EN to insert a channel-tag header word whenever the source channel changes.
module dtb_daq_merge #(
    parameter int NCH   = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                 clk_daq,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [NCH-1:0]       in_write,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic                 out_full,
    output logic                 out_write,
    output logic [WIDTH-1:0]     out_data,
    output logic [NCH-1:0]       ovf,
    output logic [15:0]          drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] fifo_mem [NCH][DEPTH];
    logic [AW:0]      cnt_q [NCH];
    logic [AW:0]      cnt_d [NCH];
    logic [AW-1:0]    wp_q  [NCH];
    logic [AW-1:0]    wp_d  [NCH];
    logic [AW-1:0]    rp_q  [NCH];
    logic [AW-1:0]    rp_d  [NCH];
    logic [CW-1:0]    last_q, last_d;
    logic             run_d_q, run_d_d;
    logic             out_write_q, out_write_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic [15:0]      drop_q, drop_d;
    logic [16:0]      drop_sum;
    logic [NCH-1:0]   pop, push_acc;
    logic             gnt_found;
    logic [CW-1:0]    gnt_idx;
    logic             run_rise;

`ifdef DAQ_MERGE_TAG_EN
    typedef enum logic {ST_DATA, ST_TAG} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    emit_q, emit_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] tag_word;
`endif

    assign run_rise = run & ~run_d_q;
    assign run_d_d  = run;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!gnt_found && cnt_q[(int'(last_q) + i) % NCH] != '0) begin
                gnt_found = 1'b1;
                gnt_idx   = CW'((int'(last_q) + i) % NCH);
            end
        end
    end

    always_comb begin
        pop         = '0;
        last_d      = last_q;
        out_write_d = 1'b0;
        out_data_d  = out_data_q;
`ifdef DAQ_MERGE_TAG_EN
        state_d  = state_q;
        emit_d   = emit_q;
        first_d  = first_q | run_rise;
        tag_word = '0;
        tag_word[WIDTH-1 -: 4] = 4'hF;
        tag_word[3:0] = 4'(gnt_idx);
        case (state_q)
            ST_DATA: begin
                if (!out_full && gnt_found) begin
                    last_d      = gnt_idx;
                    out_write_d = 1'b1;
                    // a channel switch costs one header cycle; the pop follows in TAG
                    if (first_d || gnt_idx != emit_q) begin
                        out_data_d = tag_word;
                        emit_d     = gnt_idx;
                        first_d    = 1'b0;
                        state_d    = ST_TAG;
                    end else begin
                        pop[gnt_idx] = 1'b1;
                        out_data_d   = fifo_mem[gnt_idx][rp_q[gnt_idx]];
                    end
                end
            end
            ST_TAG: begin
                if (!out_full) begin
                    pop[emit_q] = 1'b1;
                    out_write_d = 1'b1;
                    out_data_d  = fifo_mem[emit_q][rp_q[emit_q]];
                    state_d     = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
`else
        if (!out_full && gnt_found) begin
            pop[gnt_idx] = 1'b1;
            last_d       = gnt_idx;
            out_write_d  = 1'b1;
            out_data_d   = fifo_mem[gnt_idx][rp_q[gnt_idx]];
        end
`endif
    end

    always_comb begin
        push_acc = '0;
        ovf_d    = run_rise ? '0 : ovf_q;
        drop_sum = {1'b0, (run_rise ? 16'h0000 : drop_q)};
        for (int k = 0; k < NCH; k++) begin
            // a full channel still accepts when it is popped in the same cycle
            push_acc[k] = run && in_write[k] && ((cnt_q[k] != CNT_FULL) || pop[k]);
            cnt_d[k]    = cnt_q[k] + (AW+1)'(push_acc[k]) - (AW+1)'(pop[k]);
            wp_d[k]     = wp_q[k] + AW'(push_acc[k]);
            rp_d[k]     = rp_q[k] + AW'(pop[k]);
            if (run && in_write[k] && !push_acc[k]) begin
                ovf_d[k] = 1'b1;
                drop_sum = drop_sum + 17'd1;
            end
        end
        drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_daq or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
                wp_q[k]  <= '0;
                rp_q[k]  <= '0;
            end
            last_q      <= CW'(NCH-1);
            run_d_q     <= 1'b0;
            out_write_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= '0;
            drop_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            last_q      <= last_d;
            run_d_q     <= run_d_d;
            out_write_q <= out_write_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

`ifdef DAQ_MERGE_TAG_EN
    always_ff @(posedge clk_daq or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_DATA;
            emit_q  <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            emit_q  <= emit_d;
            first_q <= first_d;
        end
    end
`endif

    always_ff @(posedge clk_daq) begin
        for (int k = 0; k < NCH; k++) begin
            if (push_acc[k]) fifo_mem[k][wp_q[k]] <= in_data[k*WIDTH +: WIDTH];
        end
    end

    assign out_write  = out_write_q;
    assign out_data   = out_data_q;
    assign ovf        = ovf_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_dtb_daq_merge.sv
// Scoreboard bench for dtb_daq_merge: queue-based reference model feeds expected words to a monitor.
module tb_dtb_daq_merge;
    localparam int NCH   = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic                 clk_daq = 1'b0;
    logic                 reset_n;
    logic                 run;
    logic [NCH-1:0]       in_write;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_full;
    logic                 out_write;
    logic [WIDTH-1:0]     out_data;
    logic [NCH-1:0]       ovf;
    logic [15:0]          drop_count;

    dtb_daq_merge #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_daq(clk_daq), .reset_n(reset_n), .run(run), .in_write(in_write),
        .in_data(in_data), .out_full(out_full), .out_write(out_write),
        .out_data(out_data), .ovf(ovf), .drop_count(drop_count)
    );

    always #5 clk_daq = ~clk_daq;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [WIDTH-1:0] mq [NCH][$];
    logic [WIDTH-1:0] exp_q [$];
    int               m_last;
    int               m_drop;
    logic [NCH-1:0]   m_ovf;
    logic             m_run_d;
    int               m_emit;
    logic             m_first;
    logic             m_tag;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) mq[k].delete();
        exp_q.delete();
        m_last = NCH - 1; m_drop = 0; m_ovf = '0; m_run_d = 1'b0;
        m_emit = 0; m_first = 1'b1; m_tag = 1'b0;
    endtask

    function automatic int find_grant();
        for (int i = 1; i <= NCH; i++)
            if (mq[(m_last + i) % NCH].size() > 0) return (m_last + i) % NCH;
        return -1;
    endfunction

    // one clock edge of the spec's rules: grant on pre-edge contents, then pushes
    task automatic model_edge();
        int g;
        if (run && !m_run_d) begin
            m_ovf = '0; m_drop = 0; m_first = 1'b1;
        end
        if (!out_full) begin
`ifdef DAQ_MERGE_TAG_EN
            if (m_tag) begin
                exp_q.push_back(mq[m_emit].pop_front());
                m_tag = 1'b0;
            end else begin
                g = find_grant();
                if (g >= 0) begin
                    m_last = g;
                    if (m_first || g != m_emit) begin
                        exp_q.push_back(16'hF000 | 16'(g));
                        m_emit = g; m_first = 1'b0; m_tag = 1'b1;
                    end else exp_q.push_back(mq[g].pop_front());
                end
            end
`else
            g = find_grant();
            if (g >= 0) begin
                m_last = g;
                exp_q.push_back(mq[g].pop_front());
            end
`endif
        end
        for (int k = 0; k < NCH; k++) begin
            if (run && in_write[k]) begin
                if (mq[k].size() < DEPTH) mq[k].push_back(in_data[k*WIDTH +: WIDTH]);
                else begin
                    m_ovf[k] = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        m_run_d = run;
    endtask

    task automatic tick();
        @(posedge clk_daq);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_write = '0; in_data = '0;
    endtask

    task automatic drain(input int n);
        idle_inputs(); out_full = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_out_write", 32'(out_write), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        model_reset();
        repeat (2) @(posedge clk_daq);
        #1 reset_n = 1'b1;
    endtask

    always @(negedge clk_daq) begin
        if (reset_n) begin
            if (out_write) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_word: got %h expected no write", out_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_bad++;
                        $display("FAIL out_data: got %h expected %h", out_data, e);
                    end
                end
            end
            n_cmp++;
            if (ovf !== m_ovf) begin
                n_bad++;
                $display("FAIL ovf: got %b expected %b", ovf, m_ovf);
            end
            n_cmp++;
            if (drop_count !== 16'(m_drop)) begin
                n_bad++;
                $display("FAIL drop_count: got %0d expected %0d", drop_count, m_drop);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; out_full = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check("reset_out_write", 32'(out_write), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_drop", 32'(drop_count), 32'd0);
        @(posedge clk_daq); #1 reset_n = 1'b1;
        run = 1'b1;
        repeat (3) tick();

        // single source latency
        in_write = 4'b0100; in_data[2*WIDTH +: WIDTH] = 16'h1234;
        tick();
        idle_inputs();
`ifndef DAQ_MERGE_TAG_EN
        check("lat_not_early", 32'(out_write), 32'd0);
        tick();
        check("lat_write", 32'(out_write), 32'd1);
        check("lat_data", 32'(out_data), 32'h1234);
        tick();
        check("lat_one_cycle", 32'(out_write), 32'd0);
`endif
        drain(4);

        // collision from reset arbitration pointer
        do_reset();
        tick();
        in_write = 4'b0011;
        in_data[0 +: WIDTH] = 16'hA000; in_data[WIDTH +: WIDTH] = 16'hB000;
        tick();
        idle_inputs();
`ifndef DAQ_MERGE_TAG_EN
        tick();
        check("coll_first", 32'(out_data), 32'hA000);
        tick();
        check("coll_second_write", 32'(out_write), 32'd1);
        check("coll_second", 32'(out_data), 32'hB000);
`endif
        drain(6);

        // overflow with output blocked
        do_reset();
        out_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_write = 4'b1000; in_data[3*WIDTH +: WIDTH] = 16'(i);
            tick();
        end
        idle_inputs();
        check("ovf_flag", 32'(ovf), 32'h8);
        check("ovf_drop", 32'(drop_count), 32'd2);
        drain(12);

        // full channel with a simultaneous pop
        out_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_write = 4'b0001; in_data[0 +: WIDTH] = 16'h0C00 + 16'(i);
            tick();
        end
        out_full = 1'b0; in_data[0 +: WIDTH] = 16'h0C08;
        tick();
        check("fullpop_nodrop", 32'(drop_count), 32'd2);
        out_full = 1'b1; in_data[0 +: WIDTH] = 16'h0C09;
        tick();
        check("fullpop_still_full", 32'(drop_count), 32'd3);
        check("fullpop_ovf", 32'(ovf), 32'h9);
        drain(20);

        // run gating, then run rise clears flags
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_write = 4'b1111; in_data = {$urandom, $urandom};
            tick();
        end
        drain(4);
        run = 1'b1;
        tick();
        check("runrise_ovf", 32'(ovf), 32'd0);
        check("runrise_drop", 32'(drop_count), 32'd0);

        // randomized traffic with backpressure and occasional run drops
        for (int c = 0; c < 3000; c++) begin
            run      = ($urandom_range(0, 99) < 96);
            out_full = ($urandom_range(0, 99) < 35);
            in_write = NCH'($urandom) & NCH'($urandom);
            in_data  = {$urandom, $urandom};
            tick();
        end
        run = 1'b1;
        drain(60);

        // reset mid-burst with words still queued
        out_full = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_write = 4'b0010; in_data[WIDTH +: WIDTH] = 16'h5001 + 16'(i);
            tick();
        end
        idle_inputs(); out_full = 1'b0;
        repeat (2) tick();
        do_reset();
        drain(20);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
